// File: rtl/vdp_pkg.sv
// Shared types for the streaming dot-product engine: front-end FSM state,
// per-stage sideband bundle, and the result-width helper.
package vdp_pkg;

   typedef enum logic [0:0] {
      FIRST = 1'b0,
      ACCUM = 1'b1
   } vdp_state_e;

   typedef struct packed {
      logic valid;
      logic last;
      logic trunc;
      logic sgn;
   } vdp_sb_t;

   // Wide enough to hold N*MAX_BEATS exact 2W-bit products.
   function automatic int vdp_out_w(int n, int w, int max_beats);
      return 2 * w + $clog2(n * max_beats);
   endfunction

endpackage

// File: rtl/vdp_adder_tree_pipe.sv
// Registered pairwise reduction of N IN_W-bit products, one level per stage.
// Ports: clk, rst_n, en (global advance), in_data/in_sb, out_sum/out_sb, busy.
module vdp_adder_tree_pipe
   import vdp_pkg::*;
#(
   parameter int N = 8,
   parameter int IN_W = 16,
   localparam int LG = $clog2(N),
   localparam int SUM_W = IN_W + LG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [N*IN_W-1:0] in_data,
   input  vdp_sb_t           in_sb,
   output logic [SUM_W-1:0]  out_sum,
   output vdp_sb_t           out_sb,
   output logic              busy
);

   logic [SUM_W-1:0] leaf   [N];
   logic [SUM_W-1:0] node_d [1:N-1];
   logic [SUM_W-1:0] node_q [1:N-1];
   vdp_sb_t          sb_q   [LG];

   // Widen once at the leaves so every level adds exactly.
   always_comb begin
      for (int j = 0; j < N; j++) begin
         leaf[j] = {{LG{in_sb.sgn & in_data[j*IN_W+IN_W-1]}},
                    in_data[j*IN_W +: IN_W]};
      end
   end

   // Heap layout: node i sums children 2i and 2i+1; indices >= N are leaves.
   for (genvar i = 1; i < N; i++) begin : g_node
      if (2 * i >= N) begin : g_leaf
         assign node_d[i] = leaf[2*i-N] + leaf[2*i+1-N];
      end else begin : g_int
         assign node_d[i] = node_q[2*i] + node_q[2*i+1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < N; i++) node_q[i] <= '0;
         for (int k = 0; k < LG; k++) sb_q[k] <= '0;
      end else if (en) begin
         for (int i = 1; i < N; i++) node_q[i] <= node_d[i];
         sb_q[0] <= in_sb;
         for (int k = 1; k < LG; k++) sb_q[k] <= sb_q[k-1];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < LG; k++) busy = busy | sb_q[k].valid;
   end

   assign out_sum = node_q[1];
   assign out_sb  = sb_q[LG-1];

endmodule

// File: rtl/vec_dot_product_stream.sv
// Streaming pipelined dot product: N lanes per beat, multi-beat accumulate.
// Ports: vec_a/vec_b/in_signed/in_last with valid/ready in, result out.
module vec_dot_product_stream
   import vdp_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 8,
   parameter int MAX_BEATS = 16,
   localparam int OUT_W = vdp_out_w(N, W, MAX_BEATS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*W-1:0]   vec_a,
   input  logic [N*W-1:0]   vec_b,
   input  logic             in_signed,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_trunc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int LG    = $clog2(N);
   localparam int PW    = 2 * W;
   localparam int SUM_W = PW + LG;
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   logic             stall, accept, first, en, hit_max;
   logic [CNT_W-1:0] cnt_nx;
   vdp_sb_t          beat_sb;
   vdp_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;

   logic [N*W-1:0]   a_q, b_q;
   vdp_sb_t          i_sb_q;
   logic [N*PW-1:0]  prod_q, prod_d;
   vdp_sb_t          p_sb_q;
   logic [SUM_W-1:0] t_sum;
   vdp_sb_t          t_sb;
   logic             t_busy;

   logic [OUT_W-1:0] t_ext, acc_q, acc_d, data_q, data_d;
   logic             valid_q, valid_d, trunc_q, trunc_d;

   // Front end: vector framing and mode latch.
   always_comb begin
      stall   = valid_q && !out_ready;
      accept  = in_valid && !stall;
      first   = (state_q == FIRST);
      cnt_nx  = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
      hit_max = (cnt_nx == CNT_W'(MAX_BEATS));
      beat_sb.valid = accept;
      beat_sb.last  = in_last || hit_max;
      beat_sb.trunc = !in_last && hit_max;
      beat_sb.sgn   = first ? in_signed : mode_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      if (accept) begin
         cnt_d   = cnt_nx;
         mode_d  = beat_sb.sgn;
         state_d = beat_sb.last ? FIRST : ACCUM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FIRST;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         i_sb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         if (!stall) begin
            i_sb_q <= beat_sb;
            if (accept) begin
               a_q <= vec_a;
               b_q <= vec_b;
            end
         end
      end
   end

   // Stage P: lane products, low 2W bits are exact in either mode.
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < N; i++) begin
         if (i_sb_q.sgn) begin
            prod_d[i*PW +: PW] = PW'($signed(a_q[i*W +: W]))
                               * PW'($signed(b_q[i*W +: W]));
         end else begin
            prod_d[i*PW +: PW] = PW'(a_q[i*W +: W]) * PW'(b_q[i*W +: W]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         p_sb_q <= '0;
      end else if (!stall) begin
         prod_q <= prod_d;
         p_sb_q <= i_sb_q;
      end
   end

   assign en = !stall;

   vdp_adder_tree_pipe #(
      .N    (N),
      .IN_W (PW)
   ) u_tree (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in_data (prod_q),
      .in_sb   (p_sb_q),
      .out_sum (t_sum),
      .out_sb  (t_sb),
      .busy    (t_busy)
   );

   // Stage A: accumulate; an unstalled cycle always retires the old result.
   always_comb begin
      if (t_sb.sgn) t_ext = OUT_W'($signed(t_sum));
      else          t_ext = OUT_W'(t_sum);
      acc_d   = acc_q;
      data_d  = data_q;
      valid_d = valid_q;
      trunc_d = trunc_q;
      if (!stall) begin
         valid_d = t_sb.valid && t_sb.last;
         if (t_sb.valid) begin
            if (t_sb.last) begin
               data_d  = acc_q + t_ext;
               trunc_d = t_sb.trunc;
               acc_d   = '0;
            end else begin
               acc_d = acc_q + t_ext;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         trunc_q <= trunc_d;
      end
   end

   assign in_ready  = !stall;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_trunc = trunc_q;
   assign busy      = (state_q == ACCUM) || i_sb_q.valid || p_sb_q.valid
                    || t_busy || valid_q;

endmodule
